// File: rtl/in_feature_addr_gen.sv
// Input-feature address generator: sweeps a KxK window over the input map and issues
// two tap addresses (ports a/b) per beat, NUM_ONE_PIXEL_CYCLE beats per output pixel.
module in_feature_addr_gen #(
    parameter int unsigned ADDR_WIDTH          = 10,
    parameter int unsigned IN_FEATURE_WIDTH    = 28,
    parameter int unsigned KERNEL_SIZE         = 5,
    parameter int unsigned STRIDE              = 1,
    parameter int unsigned OUT_FEATURE_WIDTH_W = 24,
    parameter int unsigned OUT_FEATURE_WIDTH_H = 24,
    parameter int unsigned NUM_ONEMULT         = 1,
    parameter int unsigned NUM_ONE_PIXEL_CYCLE = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_addrger,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic                  addr_valid,
    output logic                  b_valid,
    output logic                  pixel_last,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned XW = (OUT_FEATURE_WIDTH_W > 1) ? $clog2(OUT_FEATURE_WIDTH_W) : 1;
    localparam int unsigned YW = (OUT_FEATURE_WIDTH_H > 1) ? $clog2(OUT_FEATURE_WIDTH_H) : 1;
    localparam int unsigned PW = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;
    localparam int unsigned BW = (NUM_ONE_PIXEL_CYCLE > 1) ? $clog2(NUM_ONE_PIXEL_CYCLE) : 1;
    localparam int unsigned CW = $clog2(KERNEL_SIZE + 2);

    localparam logic [XW-1:0] OxLast    = XW'(OUT_FEATURE_WIDTH_W - 1);
    localparam logic [YW-1:0] OyLast    = YW'(OUT_FEATURE_WIDTH_H - 1);
    localparam logic [PW-1:0] PassLast  = PW'(NUM_ONEMULT - 1);
    localparam logic [BW-1:0] BeatLast  = BW'(NUM_ONE_PIXEL_CYCLE - 1);
    localparam logic [BW+1:0] KkW       = (BW + 2)'(KK);
    localparam logic [CW-1:0] KCol      = CW'(KERNEL_SIZE);
    localparam logic [CW-1:0] KColLast  = CW'(KERNEL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] StrideA  = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] RowStepA = ADDR_WIDTH'(STRIDE * IN_FEATURE_WIDTH);
    // Offset step when tap a moves two columns right and wraps onto the next kernel row.
    localparam logic [ADDR_WIDTH-1:0] WrapA    = ADDR_WIDTH'(2 + IN_FEATURE_WIDTH - KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] WrapB    = ADDR_WIDTH'(1 + IN_FEATURE_WIDTH - KERNEL_SIZE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic [XW-1:0]           ox_q;
    logic [YW-1:0]           oy_q;
    logic [PW-1:0]           pass_q;
    logic [BW-1:0]           beat_q;
    logic [CW-1:0]           ca_q;
    logic [ADDR_WIDTH-1:0]   off_a_q, base_q, row_base_q;
    logic [ADDR_WIDTH-1:0]   address_a_q, address_b_q;
    logic                    addr_valid_q, b_valid_q, pixel_last_q, busy_q, frame_done_q;

    logic [CW-1:0]           ca_sum, ca_nx;
    logic [ADDR_WIDTH-1:0]   off_a_nx, addr_a_nx, addr_b_nx;
    logic                    last_beat, b_ok, frame_end;

    always_comb begin
        ca_sum    = ca_q + CW'(2);
        ca_nx     = ca_sum;
        off_a_nx  = off_a_q + ADDR_WIDTH'(2);
        if (ca_sum >= KCol) begin
            ca_nx    = ca_sum - KCol;
            off_a_nx = off_a_q + WrapA;
        end
        addr_a_nx = base_q + off_a_q;
        // Tap b is always tap a + 1, possibly on the next kernel row.
        addr_b_nx = base_q + off_a_q + ((ca_q == KColLast) ? WrapB : ADDR_WIDTH'(1));
        last_beat = (beat_q == BeatLast);
        b_ok      = ({1'b0, beat_q, 1'b1} < KkW);
        frame_end = last_beat && (ox_q == OxLast) && (oy_q == OyLast) && (pass_q == PassLast);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            state_q      <= StIdle;
            ox_q         <= '0;
            oy_q         <= '0;
            pass_q       <= '0;
            beat_q       <= '0;
            ca_q         <= '0;
            off_a_q      <= '0;
            base_q       <= '0;
            row_base_q   <= '0;
            address_a_q  <= '0;
            address_b_q  <= '0;
            addr_valid_q <= 1'b0;
            b_valid_q    <= 1'b0;
            pixel_last_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (enable_addrger) begin
                        address_a_q  <= addr_a_nx;
                        address_b_q  <= b_ok ? addr_b_nx : '0;
                        addr_valid_q <= 1'b1;
                        b_valid_q    <= b_ok;
                        pixel_last_q <= last_beat;
                        busy_q       <= 1'b1;
                        state_q      <= frame_end ? StDone : StRun;
                        if (last_beat) begin
                            beat_q  <= '0;
                            ca_q    <= '0;
                            off_a_q <= '0;
                            if (ox_q == OxLast) begin
                                ox_q <= '0;
                                if (oy_q == OyLast) begin
                                    oy_q       <= '0;
                                    row_base_q <= '0;
                                    base_q     <= '0;
                                    pass_q     <= (pass_q == PassLast) ? '0 : pass_q + PW'(1);
                                end else begin
                                    oy_q       <= oy_q + YW'(1);
                                    row_base_q <= row_base_q + RowStepA;
                                    base_q     <= row_base_q + RowStepA;
                                end
                            end else begin
                                ox_q   <= ox_q + XW'(1);
                                base_q <= base_q + StrideA;
                            end
                        end else begin
                            beat_q  <= beat_q + BW'(1);
                            ca_q    <= ca_nx;
                            off_a_q <= off_a_nx;
                        end
                    end else begin
                        addr_valid_q <= 1'b0;
                        b_valid_q    <= 1'b0;
                        pixel_last_q <= 1'b0;
                    end
                end
                StDone: begin
                    addr_valid_q <= 1'b0;
                    b_valid_q    <= 1'b0;
                    pixel_last_q <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign address_a  = address_a_q;
    assign address_b  = address_b_q;
    assign addr_valid = addr_valid_q;
    assign b_valid    = b_valid_q;
    assign pixel_last = pixel_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_in_feature_addr_gen.sv
// Bench for in_feature_addr_gen: default instance plus a stride-2, two-pass instance, checked
// cycle by cycle against a beat-index address model and a few constant tables.
module tb_in_feature_addr_gen;
    localparam int AW = 10;
    localparam int NB = 13;
    localparam int KS = 5;
    localparam int IW = 28;

    logic          clock = 1'b0;
    logic          reset;
    logic          en  [2];
    logic          clr [2];
    logic [AW-1:0] aa  [2];
    logic [AW-1:0] ab  [2];
    logic          va  [2];
    logic          bv  [2];
    logic          pl  [2];
    logic          bs  [2];
    logic          fd  [2];

    always #5 clock = ~clock;

    in_feature_addr_gen dut0 (
        .clock(clock), .reset(reset), .enable_addrger(en[0]), .clear(clr[0]),
        .address_a(aa[0]), .address_b(ab[0]), .addr_valid(va[0]), .b_valid(bv[0]),
        .pixel_last(pl[0]), .busy(bs[0]), .frame_done(fd[0])
    );

    in_feature_addr_gen #(
        .STRIDE(2), .OUT_FEATURE_WIDTH_W(12), .OUT_FEATURE_WIDTH_H(12), .NUM_ONEMULT(2)
    ) dut1 (
        .clock(clock), .reset(reset), .enable_addrger(en[1]), .clear(clr[1]),
        .address_a(aa[1]), .address_b(ab[1]), .addr_valid(va[1]), .b_valid(bv[1]),
        .pixel_last(pl[1]), .busy(bs[1]), .frame_done(fd[1])
    );

    int p_s  [2] = '{1, 2};
    int p_ow [2] = '{24, 12};
    int p_oh [2] = '{24, 12};
    int p_np [2] = '{1, 2};

    // Model: ms 0=idle 1=run 2=done, mn = beats issued so far in this frame.
    int ms [2], mn [2], em [2], obs [2];
    int e_aa [2], e_ab [2];
    bit e_va [2], e_bv [2], e_pl [2], e_bs [2], e_fd [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int a; int b; bit bvld; bit last; } fp_t;
    typedef struct { int d; int n; int a; int b; bit last; } sp_t;
    fp_t fp [13];
    sp_t sp [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] got(input int d);
        return {7'b0, va[d], bv[d], pl[d], bs[d], fd[d], aa[d], ab[d]};
    endfunction

    function automatic logic [31:0] expv(input int d);
        return {7'b0, e_va[d], e_bv[d], e_pl[d], e_bs[d], e_fd[d], AW'(e_aa[d]), AW'(e_ab[d])};
    endfunction

    function automatic int total(input int d);
        return p_ow[d] * p_oh[d] * p_np[d] * NB;
    endfunction

    task automatic tap_addrs(input int d, input int n, output int a, output int b,
                             output bit bvld, output bit last);
        int j, q, ox, oy, t;
        j    = n % NB;
        q    = (n / NB) % (p_ow[d] * p_oh[d]);
        ox   = q % p_ow[d];
        oy   = q / p_ow[d];
        t    = 2 * j;
        a    = ((oy * p_s[d] + t / KS) * IW + ox * p_s[d] + t % KS) % (1 << AW);
        t    = 2 * j + 1;
        bvld = (t < KS * KS);
        b    = bvld ? ((oy * p_s[d] + t / KS) * IW + ox * p_s[d] + t % KS) % (1 << AW) : 0;
        last = (j == NB - 1);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ms[d] = 0; mn[d] = 0; em[d] = -1;
            e_aa[d] = 0; e_ab[d] = 0;
            e_va[d] = 0; e_bv[d] = 0; e_pl[d] = 0; e_bs[d] = 0; e_fd[d] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        int a, b;
        bit bvld, last;
        em[d] = -1;
        if (clr[d]) begin
            ms[d] = 0; mn[d] = 0; e_aa[d] = 0; e_ab[d] = 0;
            e_va[d] = 0; e_bv[d] = 0; e_pl[d] = 0; e_bs[d] = 0; e_fd[d] = 0;
        end else if (ms[d] == 2) begin
            e_va[d] = 0; e_bv[d] = 0; e_pl[d] = 0; e_bs[d] = 0; e_fd[d] = 1;
        end else if (en[d]) begin
            tap_addrs(d, mn[d], a, b, bvld, last);
            e_aa[d] = a; e_ab[d] = b; e_va[d] = 1; e_bv[d] = bvld; e_pl[d] = last; e_bs[d] = 1;
            em[d] = mn[d];
            mn[d]++;
            ms[d] = (mn[d] == total(d)) ? 2 : 1;
        end else begin
            e_va[d] = 0; e_bv[d] = 0; e_pl[d] = 0;
        end
    endtask

    task automatic step(input bit e0, input bit c0, input bit e1, input bit c1);
        en[0] = e0; clr[0] = c0; en[1] = e1; clr[1] = c1;
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_cycle", d), got(d), expv(d));
            if (va[d]) obs[d]++;
            foreach (sp[i]) begin
                if (sp[i].d == d && sp[i].n == em[d])
                    check($sformatf("dut%0d_beat%0d", d, em[d]),
                          {11'b0, pl[d], aa[d], ab[d]},
                          {11'b0, sp[i].last, AW'(sp[i].a), AW'(sp[i].b)});
            end
        end
    endtask

    task automatic run_until_done(input int d, input bit rnd, input int max, output int steps);
        bit e;
        steps = 0;
        while (!fd[d] && steps < max) begin
            e = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (d == 0) step(e, 0, 0, 0);
            else        step(0, 0, e, 0);
            steps++;
        end
        if (!fd[d]) begin
            n_checks++;
            $display("FAIL dut%0d_done_timeout: frame_done still 0 after %0d cycles", d, steps);
        end
    endtask

    initial begin
        int steps;
        fp[0]  = '{0, 1, 1, 0};    fp[1]  = '{2, 3, 1, 0};    fp[2]  = '{4, 28, 1, 0};
        fp[3]  = '{29, 30, 1, 0};  fp[4]  = '{31, 32, 1, 0};  fp[5]  = '{56, 57, 1, 0};
        fp[6]  = '{58, 59, 1, 0};  fp[7]  = '{60, 84, 1, 0};  fp[8]  = '{85, 86, 1, 0};
        fp[9]  = '{87, 88, 1, 0};  fp[10] = '{112, 113, 1, 0}; fp[11] = '{114, 115, 1, 0};
        fp[12] = '{116, 0, 0, 1};
        sp.push_back('{0, 13, 1, 2, 0});
        sp.push_back('{0, 312, 28, 29, 0});
        sp.push_back('{0, 6, 58, 59, 0});
        sp.push_back('{0, 7487, 783, 0, 1});
        sp.push_back('{1, 13, 2, 3, 0});
        sp.push_back('{1, 1872, 0, 1, 0});

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin en[d] = 0; clr[d] = 0; obs[d] = 0; end
        model_reset();
        #3;
        check("reset_async_dut0", got(0), 32'h0);
        check("reset_async_dut1", got(1), 32'h0);
        #9 reset = 1'b0;
        @(negedge clock);
        repeat (3) step(0, 0, 0, 0);

        // First pixel against fixed constants.
        obs[0] = 0;
        for (int i = 0; i < 13; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("first_px_beat%0d", i), {10'b0, va[0], bv[0], pl[0], aa[0], ab[0]},
                  {10'b0, 1'b1, fp[i].bvld, fp[i].last, AW'(fp[i].a), AW'(fp[i].b)});
        end
        run_until_done(0, 0, 20000, steps);
        check("frame_len", 32'(steps + 13), 32'd7489);
        check("frame_beats", 32'(obs[0]), 32'd7488);
        repeat (3) step(1, 0, 0, 0);
        check("done_no_beats", 32'(obs[0]), 32'd7488);
        step(0, 1, 0, 0);
        check("clear_in_done", {31'b0, fd[0]}, 32'h0);

        // Stall of three cycles after beat 5 of pixel 0.
        obs[0] = 0;
        repeat (6) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        run_until_done(0, 0, 20000, steps);
        check("stall_frame_len", 32'(steps + 9), 32'd7492);
        check("stall_frame_beats", 32'(obs[0]), 32'd7488);

        // Clear mid-frame at pixel 100, clear beating enable.
        step(0, 1, 0, 0);
        repeat (1300) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("clear_mid", got(0), 32'h0);
        step(1, 0, 0, 0);
        check("restart_after_clear", {21'b0, va[0], aa[0]}, {21'b0, 1'b1, 10'd0});

        // Async reset mid-frame.
        repeat (50) step(1, 0, 0, 0);
        en[0] = 0;
        #3 reset = 1'b1;
        #1 check("reset_mid", got(0), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1, 0, 0, 0);
        check("restart_after_reset", {21'b0, va[0], aa[0]}, {21'b0, 1'b1, 10'd0});
        step(0, 1, 0, 0);

        // Stride 2, two passes, random stalls.
        obs[1] = 0;
        run_until_done(1, 1, 20000, steps);
        check("s2_frame_beats", 32'(obs[1]), 32'd3744);
        repeat (3) step(0, 0, 1, 0);
        check("s2_done_hold", {30'b0, va[1], fd[1]}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
